fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 27 ++
 rtl/fifo_write_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

    localparam int XFER_CNT_W = 16;

    function automatic int owner_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int burst_cnt_w(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request strictly after last_owner, wrapping.
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_owner,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        index = '0;
        // Offsets 1..NREQ so last_owner itself is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_owner) + k) % NREQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between NREQ valid/ready producers with bounded
// round-robin bursts; fifo_full is the only back-pressure.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_put,
    output logic [WIDTH-1:0]          fifo_data,
    output logic                      grant_valid,
    output logic [owner_w(NREQ)-1:0]  grant_id,
    output logic [XFER_CNT_W-1:0]     xfer_count
);

    localparam int OW = owner_w(NREQ);
    localparam int BW = burst_cnt_w(BURST);

    arb_state_e            state_q, state_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [OW-1:0]         last_owner_q, last_owner_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;

    logic          pick_found;
    logic [OW-1:0] pick_idx;
    logic          owner_valid;
    logic          xfer;
    logic [BW-1:0] burst_inc;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (OW)
    ) u_picker (
        .req        (req_valid),
        .last_owner (last_owner_q),
        .found      (pick_found),
        .index      (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        xfer_count_d = xfer_count_q;
        req_ready    = '0;
        fifo_data    = '0;

        owner_valid = req_valid[owner_q];
        // Gating with reset_n drops any in-flight transfer while reset is held.
        xfer        = reset_n && (state_q == OWN) && owner_valid && !fifo_full;
        burst_inc   = burst_cnt_q + 1'b1;
        fifo_put    = xfer;

        if (xfer) begin
            req_ready[owner_q] = 1'b1;
            fifo_data          = req_data[int'(owner_q)*WIDTH +: WIDTH];
            xfer_count_d       = xfer_count_q + 1'b1;
        end

        case (state_q)
            ARB: begin
                if (pick_found) begin
                    state_d     = OWN;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            OWN: begin
                // A dropped valid releases even when the FIFO is full.
                if (!owner_valid) begin
                    state_d      = ARB;
                    last_owner_d = owner_q;
                end else if (xfer) begin
                    burst_cnt_d = burst_inc;
                    if (burst_inc == BW'(BURST)) begin
                        state_d      = ARB;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: state_d = ARB;
        endcase

        grant_valid = reset_n && (state_q == OWN);
        grant_id    = reset_n ? owner_q : '0;
        xfer_count  = xfer_count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ARB;
            owner_q      <= '0;
            last_owner_q <= OW'(NREQ - 1);
            burst_cnt_q  <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            xfer_count_q <= xfer_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-producer word queues, a behavioural arbitration
// model checked every cycle, directed scenarios and a randomized soak.
module tb_fifo_write_arbiter;

    localparam int NREQ       = 4;
    localparam int WIDTH      = 8;
    localparam int BURST      = 4;
    localparam int FIFO_DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_put;
    logic [WIDTH-1:0]      fifo_data;
    logic                  grant_valid;
    logic [1:0]            grant_id;
    logic [15:0]           xfer_count;

    fifo_write_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .BURST (BURST)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_put    (fifo_put),
        .fifo_data   (fifo_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .xfer_count  (xfer_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Stimulus: each producer presents the head of its queue while non-empty.
    logic [WIDTH-1:0] src_q[NREQ][$];
    bit  rst_drive  = 1'b0;
    int  full_mode  = 0;     // 0: full_force, 1: random, 2: FIFO occupancy model
    bit  full_force = 1'b0;
    int  fcnt       = 0;

    // Reference model: who owns the port, who owned it last, words in this burst.
    bit m_known = 1'b0;
    bit m_owned = 1'b0;
    int m_own   = 0;
    int m_last  = NREQ - 1;
    int m_burst = 0;
    int m_total = 0;

    int               put_owner_q[$];
    logic [WIDTH-1:0] put_data_q[$];
    bit               put_hist[$];

    task automatic step();
        logic             e_put;
        logic [WIDTH-1:0] e_data;
        logic [NREQ-1:0]  e_ready;
        bit               found;
        int               c;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (src_q[i].size() != 0);
            req_data[i*WIDTH +: WIDTH] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
        case (full_mode)
            1:       fifo_full = ($urandom_range(0, 3) == 0);
            2:       fifo_full = (fcnt >= FIFO_DEPTH);
            default: fifo_full = full_force;
        endcase
        reset_n = rst_drive;

        @(negedge clk);
        e_put   = 1'b0;
        e_data  = '0;
        e_ready = '0;
        if (reset_n && m_owned && req_valid[m_own] && !fifo_full) begin
            e_put          = 1'b1;
            e_data         = req_data[m_own*WIDTH +: WIDTH];
            e_ready[m_own] = 1'b1;
        end
        check_val("fifo_put", 32'(fifo_put), 32'(e_put));
        check_val("fifo_data", 32'(fifo_data), 32'(e_data));
        check_val("req_ready", 32'(req_ready), 32'(e_ready));
        check_val("grant_valid", 32'(grant_valid), 32'(reset_n && m_owned));
        check_val("grant_id", 32'(grant_id), reset_n ? 32'(m_own) : 32'd0);
        if (m_known) check_val("xfer_count", 32'(xfer_count), 32'(m_total));
        put_hist.push_back(e_put);

        if (!reset_n) begin
            m_known = 1'b1;
            m_owned = 1'b0;
            m_own   = 0;
            m_last  = NREQ - 1;
            m_burst = 0;
            m_total = 0;
        end else if (!m_owned) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (!found && req_valid[c]) begin
                    found   = 1'b1;
                    m_owned = 1'b1;
                    m_own   = c;
                    m_burst = 0;
                end
            end
        end else if (!req_valid[m_own]) begin
            m_last  = m_own;
            m_owned = 1'b0;
        end else if (!fifo_full) begin
            m_burst++;
            m_total = (m_total + 1) % 65536;
            put_owner_q.push_back(m_own);
            put_data_q.push_back(src_q[m_own].pop_front());
            fcnt++;
            if (m_burst == BURST) begin
                m_last  = m_own;
                m_owned = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        full_mode  = 0;
        full_force = 1'b0;
        rst_drive  = 1'b0;
        step();
        step();
        rst_drive  = 1'b1;
        fcnt       = 0;
        put_owner_q.delete();
        put_data_q.delete();
        put_hist.delete();
    endtask

    initial begin
        bit exp_pat[13];
        exp_pat = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        reset_n   = 1'b0;

        // Reset mid-burst, then producer 0 wins over 2.
        do_reset();
        check_val("rst_xfer_count", 32'(xfer_count), 32'd0);
        check_val("rst_grant_valid", 32'(grant_valid), 32'd0);
        for (int k = 0; k < 6; k++) src_q[2].push_back(8'h20 + 8'(k));
        step(); step(); step();
        check_val("midburst_owner", 32'(grant_id), 32'd2);
        check_val("midburst_count", 32'(xfer_count), 32'd2);
        for (int k = 0; k < 3; k++) src_q[0].push_back(8'h00 + 8'(k));
        rst_drive = 1'b0;
        step();
        rst_drive = 1'b1;
        check_val("midrst_grant_valid", 32'(grant_valid), 32'd0);
        step();
        check_val("after_rst_grant_valid", 32'(grant_valid), 32'd1);
        check_val("after_rst_grant_id", 32'(grant_id), 32'd0);

        // Single producer, 10 words, never full.
        do_reset();
        for (int k = 0; k < 10; k++) src_q[1].push_back(8'h11 + 8'(k));
        for (int k = 0; k < 15; k++) step();
        check_val("single_xfer_count", 32'(xfer_count), 32'd10);
        check_val("single_words", 32'(put_data_q.size()), 32'd10);
        for (int k = 0; k < put_data_q.size(); k++)
            check_val("single_data", 32'(put_data_q[k]), 32'h11 + 32'(k));
        for (int k = 0; k < 13; k++)
            check_val("single_put_pattern", 32'(put_hist[k]), 32'(exp_pat[k]));

        // All four requesting continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 30; k++) src_q[i].push_back(8'(i * 64 + k));
        for (int k = 0; k < 20; k++) step();
        check_val("all4_xfer_count", 32'(xfer_count), 32'd16);
        for (int k = 0; k < 16 && k < put_owner_q.size(); k++)
            check_val("all4_rr_order", 32'(put_owner_q[k]), 32'(k / 4));

        // Back-pressure mid-burst of producer 3.
        do_reset();
        for (int k = 0; k < 6; k++) src_q[3].push_back(8'h30 + 8'(k));
        for (int k = 0; k < 8; k++) begin
            full_force = (k >= 3 && k <= 5);
            step();
        end
        full_force = 1'b0;
        check_val("bp_xfer_count", 32'(xfer_count), 32'd4);
        check_val("bp_released", 32'(grant_valid), 32'd0);
        for (int k = 3; k <= 5; k++) check_val("bp_no_put", 32'(put_hist[k]), 32'd0);

        // Early release hands over to producer 2.
        do_reset();
        src_q[0].push_back(8'hA0);
        src_q[0].push_back(8'hA1);
        for (int k = 0; k < 5; k++) src_q[2].push_back(8'hC0 + 8'(k));
        for (int k = 0; k < 5; k++) step();
        check_val("early_grant_valid", 32'(grant_valid), 32'd1);
        check_val("early_grant_id", 32'(grant_id), 32'd2);
        check_val("early_xfer_count", 32'(xfer_count), 32'd2);

        // Fill an empty 8-deep FIFO that is never drained.
        do_reset();
        full_mode = 2;
        for (int k = 0; k < 20; k++) begin
            src_q[0].push_back(8'h50 + 8'(k));
            src_q[1].push_back(8'h70 + 8'(k));
        end
        for (int k = 0; k < 30; k++) step();
        check_val("fill_xfer_count", 32'(xfer_count), 32'd8);
        check_val("fill_fifo_level", 32'(fcnt), 32'(FIFO_DEPTH));

        // Randomized soak with random back-pressure and occasional resets.
        do_reset();
        full_mode = 1;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (src_q[i].size() < 6 && $urandom_range(0, 99) < 25)
                    src_q[i].push_back(8'($urandom));
            rst_drive = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_drive = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
